// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronized column sampling,
// frame-based debounce FSM and a four-key hex history for the display.
module keypad_scan #(
    parameter int CLK_DIV  = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] key_buf
);

    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_HELD,
        S_RELEASE_CHK
    } state_t;

    logic [3:0]    col_meta_reg;
    logic [3:0]    col_sync_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]    row_idx_reg;
    logic [3:0]    key_row_reg;
    logic          acc_hit_reg;
    logic [3:0]    acc_code_reg;

    state_t        state_reg, state_next;
    logic [3:0]    cand_reg, cand_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic          key_valid_reg, key_valid_next;
    logic          key_down_reg, key_down_next;
    logic [15:0]   key_buf_reg, key_buf_next;

    logic          tick;
    logic          frame_end;
    logic [3:0]    col_pressed;
    logic          row_hit;
    logic [1:0]    row_col;
    logic          frame_hit;
    logic [3:0]    frame_code;
    logic          cand_match;
    logic [3:0]    cnt_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
        end else begin
            col_meta_reg <= key_col;
            col_sync_reg <= col_meta_reg;
        end
    end

    assign tick      = (presc_reg == PW'(CLK_DIV - 1));
    assign frame_end = tick && (row_idx_reg == 2'd3);

    // key_row is held in its own register so the row lines never glitch on a decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            row_idx_reg <= 2'd0;
            key_row_reg <= 4'b1110;
        end else if (tick) begin
            presc_reg   <= '0;
            row_idx_reg <= row_idx_reg + 2'd1;
            key_row_reg <= {key_row_reg[2:0], key_row_reg[3]};
        end else begin
            presc_reg   <= presc_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_pressed[gi] = ~col_sync_reg[gi];
        end
    endgenerate

    always_comb begin
        row_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (col_pressed[i]) begin
                row_col = 2'(i);
            end
        end
    end

    assign row_hit = |col_pressed;

    // Rows are visited in ascending order, so the first hit of a frame is its lowest code.
    assign frame_hit  = acc_hit_reg | row_hit;
    assign frame_code = acc_hit_reg ? acc_code_reg : {row_idx_reg, row_col};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= 4'd0;
        end else if (frame_end) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= 4'd0;
        end else if (tick) begin
            acc_hit_reg  <= frame_hit;
            acc_code_reg <= frame_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            cand_reg      <= 4'd0;
            cnt_reg       <= 4'd0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            key_down_reg  <= 1'b0;
            key_buf_reg   <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_down_reg  <= key_down_next;
            key_buf_reg   <= key_buf_next;
        end
    end

    assign cand_match = frame_hit && (frame_code == cand_reg);
    assign cnt_inc    = cnt_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_down_next  = key_down_reg;
        key_buf_next   = key_buf_reg;
        if (frame_end) begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_hit) begin
                        cand_next  = frame_code;
                        cnt_next   = 4'd1;
                        state_next = S_PRESS_CHK;
                    end
                end
                S_PRESS_CHK: begin
                    if (cand_match) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= 4'(DEBOUNCE)) begin
                            state_next     = S_HELD;
                            key_code_next  = cand_reg;
                            key_valid_next = 1'b1;
                            key_down_next  = 1'b1;
                            key_buf_next   = {key_buf_reg[11:0], cand_reg};
                        end
                    end else if (frame_hit) begin
                        cand_next = frame_code;
                        cnt_next  = 4'd1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_HELD: begin
                    // A different key while held is treated as release, never as a new press.
                    if (!cand_match) begin
                        cnt_next   = 4'd1;
                        state_next = S_RELEASE_CHK;
                    end
                end
                S_RELEASE_CHK: begin
                    if (cand_match) begin
                        state_next = S_HELD;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= 4'(DEBOUNCE)) begin
                            state_next    = S_IDLE;
                            key_down_next = 1'b0;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign key_row   = key_row_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_down  = key_down_reg;
    assign key_buf   = key_buf_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a directed frame table, reset corner cases and random key
// activity checked against a frame-level debounce model.
module tb_keypad_scan;

    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * CLK_DIV;

    logic        clk;
    logic        reset_n;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] key_buf;

    logic [15:0] keys;

    int vectors;
    int miscompares;

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .key_buf   (key_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a closed switch pulls its column low while its row is driven low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!key_row[r]) begin
                key_col = key_col & ~keys[4*r +: 4];
            end
        end
    end

    typedef struct {
        logic [15:0] keys;
        int          reps;
        bit          valid;
        logic [3:0]  code;
        bit          down;
        logic [15:0] kbuf;
    } vec_t;

    vec_t vecs[$];

    int          m_win[$];
    bit          m_down;
    bit          m_valid;
    logic [3:0]  m_code;
    logic [3:0]  m_cand;
    logic [15:0] m_buf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [15:0] k, input int n, input bit v, input logic [3:0] c,
                           input bit d, input logic [15:0] b);
        vec_t e;
        e.keys = k; e.reps = n; e.valid = v; e.code = c; e.down = d; e.kbuf = b;
        vecs.push_back(e);
    endtask

    function automatic int lowest_key(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_down  = 1'b0;
        m_valid = 1'b0;
        m_code  = 4'd0;
        m_cand  = 4'd0;
        m_buf   = 16'h0000;
    endtask

    // Press: the last DEBOUNCE frames since the previous release all show the same key.
    // Release: the last DEBOUNCE frames since the press all lack the held key.
    task automatic model_frame(input int fr);
        bit all_same;
        bit none_cand;
        int last;
        int v;
        m_valid = 1'b0;
        m_win.push_back(fr);
        if (m_win.size() >= DEBOUNCE) begin
            all_same  = 1'b1;
            none_cand = 1'b1;
            last      = m_win[m_win.size() - 1];
            for (int i = 0; i < DEBOUNCE; i++) begin
                v = m_win[m_win.size() - 1 - i];
                if (v != last) all_same = 1'b0;
                if (v == int'(m_cand)) none_cand = 1'b0;
            end
            if (!m_down && all_same && last >= 0) begin
                m_cand  = 4'(last);
                m_code  = 4'(last);
                m_buf   = {m_buf[11:0], 4'(last)};
                m_down  = 1'b1;
                m_valid = 1'b1;
                m_win.delete();
            end else if (m_down && none_cand) begin
                m_down = 1'b0;
                m_win.delete();
            end
        end
    endtask

    // Applies one frame of key state; assumes the call starts just after a frame boundary.
    task automatic run_frame(input logic [15:0] m, output logic [15:0] vmask, output int row_err);
        logic [3:0] er;
        keys    = m;
        vmask   = 16'h0000;
        row_err = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk);
            #1;
            vmask[k-1] = key_valid;
            er = ~(4'b0001 << ((k / CLK_DIV) % 4));
            if (key_row !== er) row_err++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   key_row,   4'b1110);
        check({tag, "_code"},  key_code,  4'h0);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_down"},  key_down,  1'b0);
        check({tag, "_buf"},   key_buf,   16'h0000);
    endtask

    initial begin
        logic [15:0] vmask;
        logic [15:0] exp_mask;
        logic [15:0] rk;
        int          row_err;
        int          sel;

        vectors     = 0;
        miscompares = 0;
        keys        = 16'h0001;
        reset_n     = 1'b0;

        // Reset held with changing column activity.
        repeat (3) @(posedge clk);
        keys = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        $display("reset held: row=%b code=%h down=%b buf=%h", key_row, key_code, key_down, key_buf);
        keys = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;

        add_vec(16'h0200, 2, 0, 4'h0, 0, 16'h0000);
        add_vec(16'h0200, 1, 1, 4'h9, 1, 16'h0009);
        add_vec(16'h0200, 7, 0, 4'h9, 1, 16'h0009);
        add_vec(16'h0000, 2, 0, 4'h9, 1, 16'h0009);
        add_vec(16'h0000, 1, 0, 4'h9, 0, 16'h0009);
        add_vec(16'h0020, 2, 0, 4'h9, 0, 16'h0009);
        add_vec(16'h0000, 1, 0, 4'h9, 0, 16'h0009);
        add_vec(16'h0020, 2, 0, 4'h9, 0, 16'h0009);
        add_vec(16'h0020, 1, 1, 4'h5, 1, 16'h0095);
        add_vec(16'h0000, 2, 0, 4'h5, 1, 16'h0095);
        add_vec(16'h0020, 1, 0, 4'h5, 1, 16'h0095);
        add_vec(16'h0000, 2, 0, 4'h5, 1, 16'h0095);
        add_vec(16'h0000, 1, 0, 4'h5, 0, 16'h0095);
        add_vec(16'h0180, 3, 1, 4'h7, 1, 16'h0957);
        add_vec(16'h0000, 3, 0, 4'h7, 0, 16'h0957);
        add_vec(16'h0002, 3, 1, 4'h1, 1, 16'h9571);
        add_vec(16'h0000, 3, 0, 4'h1, 0, 16'h9571);
        add_vec(16'h0004, 3, 1, 4'h2, 1, 16'h5712);
        add_vec(16'h0000, 3, 0, 4'h2, 0, 16'h5712);
        add_vec(16'h0008, 3, 1, 4'h3, 1, 16'h7123);
        add_vec(16'h0000, 3, 0, 4'h3, 0, 16'h7123);
        add_vec(16'h0010, 3, 1, 4'h4, 1, 16'h1234);
        add_vec(16'h0000, 3, 0, 4'h4, 0, 16'h1234);
        add_vec(16'h0020, 3, 1, 4'h5, 1, 16'h2345);
        add_vec(16'h0000, 3, 0, 4'h5, 0, 16'h2345);
        add_vec(16'h0008, 3, 1, 4'h3, 1, 16'h3453);
        add_vec(16'h0040, 2, 0, 4'h3, 1, 16'h3453);
        add_vec(16'h0040, 1, 0, 4'h3, 0, 16'h3453);
        add_vec(16'h0040, 2, 0, 4'h3, 0, 16'h3453);
        add_vec(16'h0040, 1, 1, 4'h6, 1, 16'h4536);
        add_vec(16'h0000, 3, 0, 4'h6, 0, 16'h4536);

        foreach (vecs[i]) begin
            for (int rep = 0; rep < vecs[i].reps; rep++) begin
                run_frame(vecs[i].keys, vmask, row_err);
                exp_mask = (rep == vecs[i].reps - 1 && vecs[i].valid) ? 16'h8000 : 16'h0000;
                check("tbl_valid_pulse", vmask, exp_mask);
                check("tbl_row_seq_errors", row_err, 0);
            end
            check("tbl_code", key_code, vecs[i].code);
            check("tbl_down", key_down, vecs[i].down);
            check("tbl_buf",  key_buf,  vecs[i].kbuf);
            $display("vec %0d: keys=%h x%0d code=%h down=%b buf=%h", i, vecs[i].keys, vecs[i].reps,
                     key_code, key_down, key_buf);
        end

        // Reset asserted while key 0xA is held, between clock edges.
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h0400, vmask, row_err);
        end
        check("held_a_down", key_down, 1'b1);
        check("held_a_code", key_code, 4'hA);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        $display("async reset while held: row=%b code=%h down=%b buf=%h", key_row, key_code, key_down, key_buf);
        @(negedge clk);
        reset_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0400, vmask, row_err);
            check("rearm_valid_pulse", vmask, (f == 2) ? 16'h8000 : 16'h0000);
            check("rearm_row_seq_errors", row_err, 0);
        end
        check("rearm_code", key_code, 4'hA);
        check("rearm_down", key_down, 1'b1);
        check("rearm_buf",  key_buf,  16'h000A);
        $display("rearm after reset: code=%h down=%b buf=%h", key_code, key_down, key_buf);

        // Random key activity, sticky so that debounce runs actually form.
        keys = 16'h0000;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        rk = 16'h0000;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 99) >= 65) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       rk = 16'h0000;
                    1, 2:    rk = 16'h0001 << $urandom_range(0, 15);
                    default: rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                endcase
            end
            run_frame(rk, vmask, row_err);
            model_frame(lowest_key(rk));
            check("rnd_valid_pulse", vmask, m_valid ? 16'h8000 : 16'h0000);
            check("rnd_row_seq_errors", row_err, 0);
            check("rnd_code", key_code, m_code);
            check("rnd_down", key_down, m_down);
            check("rnd_buf",  key_buf,  m_buf);
            $display("rnd %0d: keys=%h valid=%b code=%h down=%b buf=%h", f, rk, vmask[15],
                     key_code, key_down, key_buf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
